// File: rtl/multicycle_control_unit_if.sv
// Datapath <-> sequencer bundle for KGP-miniRISC.
// Control drives PC and strobes; datapath returns opcode, flags and results.
interface multicycle_control_unit_if;
  logic [5:0]  opcode;
  logic [2:0]  flags;
  logic [31:0] address;
  logic [31:0] data_to_mem;
  logic [31:0] PCin;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        DataPCSel;
  logic        RegSelect;
  logic [2:0]  ALUop;
  logic [1:0]  ALUinSel;

  modport master (
    input  opcode, flags, address, data_to_mem,
    output PCin, RegWrite, MemRead, MemWrite,
    output MemtoReg, DataPCSel, RegSelect,
    output ALUop, ALUinSel
  );

  modport slave (
    output opcode, flags, address, data_to_mem,
    input  PCin, RegWrite, MemRead, MemWrite,
    input  MemtoReg, DataPCSel, RegSelect,
    input  ALUop, ALUinSel
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// KGP-miniRISC multi-cycle sequencer and program counter.
// FETCH -> EXEC -> [MEM] -> WB -> FETCH; HALT absorbs until reset.
module multicycle_control_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_unit_if.master bus,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH, EXEC, MEM, WB, HALT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_q, pc_nx;
  logic [5:0]  ir;

  logic is_r, is_i, is_lw, is_sw, is_br;
  logic is_bz, is_bnz, is_call, is_jr;
  logic is_halt, is_bad;

  logic [2:0] d_aluop;
  logic [1:0] d_alusel;
  logic       d_m2r, d_rsel, d_dsel, d_wr;
  logic       taken, retire_ev;
  logic [31:0] target;

  assign is_r    = ir == 6'h00;
  assign is_i    = ir == 6'h01;
  assign is_lw   = ir == 6'h02;
  assign is_sw   = ir == 6'h03;
  assign is_br   = ir == 6'h04;
  assign is_bz   = ir == 6'h05;
  assign is_bnz  = ir == 6'h06;
  assign is_call = ir == 6'h07;
  assign is_jr   = ir == 6'h08;
  assign is_halt = ir == 6'h3F;
  assign is_bad  = !(ir <= 6'h08 || is_halt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      ir      <= 6'h00;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH)
        ir <= bus.opcode;
      if (state == EXEC && is_bad)
        illegal <= 1'b1;
      if (state == WB)
        pc_q <= pc_nx;
      if (retire_ev && !(&retired))
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: state_nx = EXEC;
      EXEC: begin
        if (is_halt)
          state_nx = HALT;
        else if (is_lw || is_sw)
          state_nx = MEM;
        else
          state_nx = WB;
      end
      MEM:     state_nx = WB;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  assign retire_ev = (state == WB)
                  || (state == EXEC && is_halt);

  // Flags and targets are only looked at on the WB exit edge
  always_comb begin
    taken  = 1'b0;
    target = bus.address;
    unique case (1'b1)
      is_br:   taken = 1'b1;
      is_bz:   taken = bus.flags[1];
      is_bnz:  taken = !bus.flags[1];
      is_call: taken = 1'b1;
      is_jr: begin
        taken  = 1'b1;
        target = bus.data_to_mem;
      end
      default: ;
    endcase
    pc_nx = taken ? target : pc_q + 32'd1;
  end

  always_comb begin
    d_aluop  = 3'b000;
    d_alusel = 2'b00;
    d_m2r    = 1'b0;
    d_rsel   = 1'b0;
    d_dsel   = 1'b0;
    d_wr     = 1'b0;
    unique case (1'b1)
      is_r: begin
        d_m2r = 1'b1;
        d_wr  = 1'b1;
      end
      is_i: begin
        d_aluop  = 3'b001;
        d_alusel = 2'b10;
        d_m2r    = 1'b1;
        d_wr     = 1'b1;
      end
      is_lw: begin
        d_aluop  = 3'b010;
        d_alusel = 2'b10;
        d_wr     = 1'b1;
      end
      is_sw: begin
        d_aluop  = 3'b010;
        d_alusel = 2'b10;
      end
      is_bz, is_bnz, is_jr:
        d_alusel = 2'b01;
      is_call: begin
        d_rsel = 1'b1;
        d_dsel = 1'b1;
        d_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCin = pc_q;

  always_comb begin
    bus.ALUop     = 3'b000;
    bus.ALUinSel  = 2'b00;
    bus.MemtoReg  = 1'b0;
    bus.RegSelect = 1'b0;
    bus.DataPCSel = 1'b0;
    if (state == EXEC || state == MEM || state == WB) begin
      bus.ALUop     = d_aluop;
      bus.ALUinSel  = d_alusel;
      bus.MemtoReg  = d_m2r;
      bus.RegSelect = d_rsel;
      bus.DataPCSel = d_dsel;
    end
    bus.MemRead  = is_lw && (state == MEM || state == WB);
    bus.MemWrite = is_sw && state == MEM;
    bus.RegWrite = d_wr && state == WB;
    halted       = state == HALT;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Random instruction stream against a per-instruction reference model.
// Covers latency, strobes, branches, halt, mid-instruction reset, saturation.
module tb_multicycle_control_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0010;
  localparam int          CW     = 2;
  localparam int          SATV   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          halted, illegal;
  logic [CW-1:0] retired;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(
    .RESET_PC (RST_PC),
    .CNT_WIDTH(CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.master),
    .halted (halted),
    .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;
  int          m_ret;
  logic        m_ill;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > SATV) ? SATV : n;
  endfunction

  task automatic chk_idle_state();
    check("rst_pc", bus.PCin, RST_PC);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retired", retired, 0);
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_memread", bus.MemRead, 0);
    check("rst_memwrite", bus.MemWrite, 0);
    check("rst_aluop", bus.ALUop, 0);
  endtask

  task automatic model_reset();
    m_pc  = RST_PC;
    m_ret = 0;
    m_ill = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk_idle_state();
  endtask

  task automatic chk_decode(input logic [5:0] op);
    case (op)
      6'h00: begin
        check("aluop_r", bus.ALUop, 3'b000);
        check("alusel_r", bus.ALUinSel, 2'b00);
        check("m2r_r", bus.MemtoReg, 1);
        check("rsel_r", bus.RegSelect, 0);
        check("dsel_r", bus.DataPCSel, 0);
      end
      6'h01: begin
        check("aluop_i", bus.ALUop, 3'b001);
        check("alusel_i", bus.ALUinSel, 2'b10);
        check("m2r_i", bus.MemtoReg, 1);
      end
      6'h02: begin
        check("aluop_lw", bus.ALUop, 3'b010);
        check("alusel_lw", bus.ALUinSel, 2'b10);
        check("m2r_lw", bus.MemtoReg, 0);
      end
      6'h03: begin
        check("aluop_sw", bus.ALUop, 3'b010);
        check("alusel_sw", bus.ALUinSel, 2'b10);
      end
      6'h05, 6'h06, 6'h08:
        check("alusel_br", bus.ALUinSel, 2'b01);
      6'h07: begin
        check("rsel_call", bus.RegSelect, 1);
        check("dsel_call", bus.DataPCSel, 1);
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0]  op,
                           input bit          rst_mid,
                           input logic [31:0] adr);
    bit          hlt, wr, lw, sw, bad;
    int          len;
    logic [31:0] nxt;
    bus.opcode      = op;
    bus.address     = adr;
    bus.data_to_mem = $urandom;
    bus.flags       = 3'($urandom_range(0, 7));
    hlt = op == 6'h3F;
    lw  = op == 6'h02;
    sw  = op == 6'h03;
    wr  = op == 6'h00 || op == 6'h01 || lw || op == 6'h07;
    bad = !(op <= 6'h08 || hlt);
    len = hlt ? 2 : ((lw || sw) ? 4 : 3);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      check("pc_hold", bus.PCin, m_pc);
      check("regwrite", bus.RegWrite, wr && c == len);
      check("memread", bus.MemRead, lw && c >= 3);
      check("memwrite", bus.MemWrite, sw && c == 3);
      check("halted_run", halted, 0);
      if (c >= 2) chk_decode(op);
      if (rst_mid && c == 3) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("mid_rst_pc", bus.PCin, RST_PC);
        check("mid_rst_memread", bus.MemRead, 0);
        check("mid_rst_retired", retired, 0);
        check("mid_rst_illegal", illegal, 0);
        return;
      end
      if (c < len) @(posedge clk);
    end
    @(posedge clk);
    #1;
    case (op)
      6'h04:   nxt = adr;
      6'h05:   nxt = bus.flags[1] ? adr : m_pc + 32'd1;
      6'h06:   nxt = !bus.flags[1] ? adr : m_pc + 32'd1;
      6'h07:   nxt = adr;
      6'h08:   nxt = bus.data_to_mem;
      default: nxt = m_pc + 32'd1;
    endcase
    m_ret++;
    if (bad) m_ill = 1'b1;
    if (!hlt) m_pc = nxt;
    check("retired", retired, sat(m_ret));
    check("illegal", illegal, m_ill);
    check("halted", halted, hlt);
    check("pc_next", bus.PCin, m_pc);
    if (hlt) begin
      for (int k = 0; k < 100; k++) begin
        bus.opcode      = 6'($urandom);
        bus.flags       = 3'($urandom_range(0, 7));
        bus.address     = $urandom;
        bus.data_to_mem = $urandom;
        @(negedge clk);
        if (k % 10 == 0) begin
          check("halt_stay", halted, 1);
          check("halt_pc", bus.PCin, m_pc);
          check("halt_wr",
                {bus.RegWrite, bus.MemRead, bus.MemWrite}, 0);
          check("halt_ret", retired, sat(m_ret));
        end
      end
      do_reset();
    end
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] adr;
    int          r;
    bus.opcode      = 6'h00;
    bus.flags       = 3'b000;
    bus.address     = 32'h0;
    bus.data_to_mem = 32'h0;
    model_reset();
    do_reset();
    for (int i = 0; i < 3; i++)
      run_instr(6'h00, 1'b0, $urandom);
    run_instr(6'h04, 1'b0, 32'hFFFF_FFFF);
    run_instr(6'h00, 1'b0, $urandom);
    run_instr(6'h2A, 1'b0, $urandom);
    run_instr(6'h02, 1'b1, $urandom);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)
        op = 6'h3F;
      else if (r < 12)
        op = 6'($urandom_range(9, 62));
      else
        op = 6'($urandom_range(0, 8));
      adr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF
                                        : $urandom;
      run_instr(op,
                op == 6'h02 && $urandom_range(0, 3) == 0,
                adr);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
